bin_to_bcd_seq: RTL

Parametrised, sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm, one shift per clock. It converts a WIDTH-bit input to DIGITS packed BCD digits behind a start/done handshake. It is the general-width successor to the fixed 8-bit combinational converter and feeds the calculator's seven-segment display path. It trades latency for area so that wide operands do not need a deep add-3 array.

---
 rtl/bcd_pkg.sv | 10 +
 rtl/add_three_digit.sv | 9 +
 rtl/bin_to_bcd_seq.sv | 90 +++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM states, digit constants and digit-count helper for BCD conversion
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] ADJ_ADD = 4'd3;
  function automatic int digits_for_width(input int w);
    return (w * 30103) / 100000 + 1;
  endfunction
endpackage

// File: rtl/add_three_digit.sv
// add_three_digit: double-dabble digit correction, adds 3 to a BCD digit that is 5 or more
module add_three_digit
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);
  assign o_digit = (i_digit >= ADJ_THRESH) ? i_digit + ADJ_ADD : i_digit;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: one-shift-per-clock double-dabble binary to BCD converter; BCD_SIGNED_EN enables two's complement input with sign output
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = digits_for_width(WIDTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [WIDTH-1:0]              bin,
  output logic                          ready,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          sign
);
  localparam int SW    = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [SW-1:0]      r_scr;
  logic [WIDTH-1:0]   r_bin;
  logic [SW-1:0]      r_bcd;
  logic               r_done;
  logic [SW-1:0]      w_adj;
  logic [SW+WIDTH-1:0] w_shift;
  logic [WIDTH-1:0]   w_mag;
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    add_three_digit u_adj (
      .i_digit(r_scr[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
      .o_digit(w_adj[BCD_DIGIT_W*i +: BCD_DIGIT_W])
    );
  end
  assign w_shift = {w_adj, r_bin} << 1;
`ifdef BCD_SIGNED_EN
  logic r_sign;
  logic r_sign_cap;
  assign w_mag = bin[WIDTH-1] ? -bin : bin;
  assign sign  = r_sign;
  // capture the operand sign at start and publish it alongside the result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sign     <= 1'b0;
      r_sign_cap <= 1'b0;
    end else begin
      if (r_state == IDLE && start) r_sign_cap <= bin[WIDTH-1];
      if (r_state == DONE) r_sign <= r_sign_cap;
    end
  end
`else
  assign w_mag = bin;
  assign sign  = 1'b0;
`endif
  assign ready = (r_state == IDLE);
  assign done  = r_done;
  assign bcd   = r_bcd;
  // conversion FSM: load, WIDTH adjust-and-shift steps, then publish the scratch as the result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_scr   <= '0;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_bin   <= w_mag;
          r_scr   <= '0;
          r_cnt   <= CNT_W'(WIDTH);
          r_state <= SHIFT;
        end
        SHIFT: begin
          r_scr <= w_shift[SW+WIDTH-1:WIDTH];
          r_bin <= w_shift[WIDTH-1:0];
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) r_state <= DONE;
        end
        DONE: begin
          r_bcd   <= r_scr;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
